fop_mac: RTL and testbench

Parametrised, multi-channel successor to `fop`. It performs fixed-point multiply-accumulate across `CHANNELS` independent lanes. Each lane accumulates `ACC_LEN` accepted sample pairs, then rescales the sum by `FRAC` bits, optionally saturates it, and presents the result on a valid/ready output port. It keeps the `fop` control pattern (`clk`, `reset`, `enable`) and adds streaming handshakes, channel parallelism and overflow reporting.

---
 rtl/fop_mac_if.sv | 27 ++
 rtl/fop_mac.sv | 141 ++++++++++++++
 tb/tb_fop_mac.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fop_mac_if.sv
// fop_mac_if: streaming bus for fop_mac.
//   in_valid/in_ready/in_a/in_b        : sample-pair input handshake, lanes packed LSB-first
//   out_valid/out_ready/out_data/out_ovf: result output handshake with per-lane overflow flags
// master = producer of samples / consumer of results; slave = the MAC block.
interface fop_mac_if #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned CHANNELS = 4
);
    logic                        in_valid;
    logic                        in_ready;
    logic [CHANNELS*WIDTH-1:0]   in_a;
    logic [CHANNELS*WIDTH-1:0]   in_b;
    logic                        out_valid;
    logic                        out_ready;
    logic [CHANNELS*WIDTH-1:0]   out_data;
    logic [CHANNELS-1:0]         out_ovf;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/fop_mac.sv
// fop_mac: multi-lane fixed-point multiply-accumulate.
// Each lane sums ACC_LEN products a*b, rescales by FRAC bits, optionally saturates,
// and presents the result on a valid/ready port.
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset
//   enable : global advance, 0 freezes all state
//   clear  : synchronous flush of accumulation and output (ignores enable)
//   busy   : state is not ACCUM or a partial accumulation is in progress
//   bus    : sample input and result output handshakes (fop_mac_if.slave)
module fop_mac #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned FRAC     = 8,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned ACC_LEN  = 8,
    parameter int unsigned SATURATE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        clear,
    output logic        busy,
    fop_mac_if.slave    bus
);
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
    localparam int unsigned AW = PW + CW;
    localparam int unsigned HW = AW - WIDTH + 1;

    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [1:0] ACCUM  = 2'd0;
    localparam logic [1:0] FINISH = 2'd1;
    localparam logic [1:0] HOLD   = 2'd2;

    logic [1:0]                 state_q, state_d;
    logic [CW-1:0]              count_q, count_d;
    logic signed [AW-1:0]       acc_q [CHANNELS];
    logic signed [AW-1:0]       acc_d [CHANNELS];
    logic                       out_valid_q, out_valid_d;
    logic [CHANNELS*WIDTH-1:0]  out_data_q, out_data_d;
    logic [CHANNELS-1:0]        out_ovf_q, out_ovf_d;

    logic                       in_ready_c;
    logic                       accept_c;
    logic signed [PW-1:0]       prod_c    [CHANNELS];
    logic [WIDTH-1:0]           lane_res_c [CHANNELS];
    logic [CHANNELS-1:0]        lane_ovf_c;

    // Reset gating keeps in_ready low while reset is held.
    assign in_ready_c = reset & enable & (state_q == ACCUM) & ~clear;
    assign accept_c   = bus.in_valid & in_ready_c;

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ovf   = out_ovf_q;
    assign busy          = (state_q != ACCUM) || (count_q != '0);

    // Per-lane product and rescale; overflow when the bits above the result sign disagree.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        logic signed [AW-1:0] shifted;
        logic [HW-1:0]        hi;

        assign prod_c[g] = PW'($signed(bus.in_a[g*WIDTH +: WIDTH]))
                         * PW'($signed(bus.in_b[g*WIDTH +: WIDTH]));
        assign shifted       = acc_q[g] >>> FRAC;
        assign hi            = shifted[AW-1:WIDTH-1];
        assign lane_ovf_c[g] = ~((&hi) | ~(|hi));
        assign lane_res_c[g] = (lane_ovf_c[g] && (SATURATE != 0))
                             ? (shifted[AW-1] ? SAT_MIN : SAT_MAX)
                             : shifted[WIDTH-1:0];
    end

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;

        if (clear) begin
            for (int i = 0; i < CHANNELS; i++) acc_d[i] = '0;
            count_d     = '0;
            out_valid_d = 1'b0;
            out_ovf_d   = '0;
            state_d     = ACCUM;
        end else if (enable) begin
            case (state_q)
                ACCUM: begin
                    if (accept_c) begin
                        for (int i = 0; i < CHANNELS; i++)
                            acc_d[i] = acc_q[i] + AW'(prod_c[i]);
                        if (count_q == CW'(ACC_LEN - 1)) begin
                            count_d = '0;
                            state_d = FINISH;
                        end else begin
                            count_d = count_q + CW'(1);
                        end
                    end
                end
                FINISH: begin
                    for (int i = 0; i < CHANNELS; i++)
                        out_data_d[i*WIDTH +: WIDTH] = lane_res_c[i];
                    out_ovf_d   = lane_ovf_c;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end
                HOLD: begin
                    if (out_valid_q && bus.out_ready) begin
                        out_valid_d = 1'b0;
                        for (int i = 0; i < CHANNELS; i++) acc_d[i] = '0;
                        state_d = ACCUM;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ACCUM;
            count_q     <= '0;
            for (int i = 0; i < CHANNELS; i++) acc_q[i] <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
        end
    end
endmodule

// File: tb/tb_fop_mac.sv
// tb_fop_mac: scoreboard bench for fop_mac (2 lanes, ACC_LEN 4, FRAC 8).
// Two instances share stimulus: one saturating, one wrapping.
module tb_fop_mac;
    typedef struct {
        logic [31:0] sat;
        logic [31:0] wrap;
        logic [1:0]  ovf;
    } exp_t;

    logic tb_clk;
    logic rst_n;
    logic enable;
    logic clear;
    logic busy0, busy1;

    fop_mac_if #(.WIDTH(16), .CHANNELS(2)) bus0 ();
    fop_mac_if #(.WIDTH(16), .CHANNELS(2)) bus1 ();

    assign bus1.in_valid  = bus0.in_valid;
    assign bus1.in_a      = bus0.in_a;
    assign bus1.in_b      = bus0.in_b;
    assign bus1.out_ready = bus0.out_ready;

    fop_mac #(.WIDTH(16), .FRAC(8), .CHANNELS(2), .ACC_LEN(4), .SATURATE(1)) u_sat (
        .clk(tb_clk), .reset(rst_n), .enable(enable), .clear(clear), .busy(busy0), .bus(bus0)
    );

    fop_mac #(.WIDTH(16), .FRAC(8), .CHANNELS(2), .ACC_LEN(4), .SATURATE(0)) u_wrap (
        .clk(tb_clk), .reset(rst_n), .enable(enable), .clear(clear), .busy(busy1), .bus(bus1)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model and output monitor, sampled mid-cycle.
    longint           acc_m [2];
    int               cnt_m;
    logic signed [15:0] m_a, m_b;
    longint           m_r;
    exp_t             m_e;
    exp_t             mon_e;

    always @(negedge tb_clk) begin
        if (!rst_n || clear) begin
            sb.delete();
            acc_m[0] = 0;
            acc_m[1] = 0;
            cnt_m    = 0;
        end else if (enable) begin
            if (bus0.out_valid && bus0.out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 64'd1, 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("data_sat",  64'(bus0.out_data), 64'(mon_e.sat));
                    check("data_wrap", 64'(bus1.out_data), 64'(mon_e.wrap));
                    check("ovf_sat",   64'(bus0.out_ovf),  64'(mon_e.ovf));
                    check("ovf_wrap",  64'(bus1.out_ovf),  64'(mon_e.ovf));
                end
            end
            if (bus0.in_valid && bus0.in_ready) begin
                for (int l = 0; l < 2; l++) begin
                    m_a = bus0.in_a[l*16 +: 16];
                    m_b = bus0.in_b[l*16 +: 16];
                    acc_m[l] = acc_m[l] + longint'(m_a) * longint'(m_b);
                end
                cnt_m++;
                if (cnt_m == 4) begin
                    for (int l = 0; l < 2; l++) begin
                        m_r = acc_m[l] >>> 8;
                        m_e.ovf[l] = (m_r > 32767) || (m_r < -32768);
                        m_e.wrap[l*16 +: 16] = 16'(m_r);
                        if (m_r > 32767)       m_e.sat[l*16 +: 16] = 16'h7FFF;
                        else if (m_r < -32768) m_e.sat[l*16 +: 16] = 16'h8000;
                        else                   m_e.sat[l*16 +: 16] = 16'(m_r);
                        acc_m[l] = 0;
                    end
                    cnt_m = 0;
                    sb.push_back(m_e);
                end
            end
        end
    end

    // Offer one sample pair and wait (bounded) until it is accepted.
    task automatic send(input logic [15:0] a0, input logic [15:0] b0,
                        input logic [15:0] a1, input logic [15:0] b1);
        int n = 0;
        bus0.in_valid = 1'b1;
        bus0.in_a     = {a1, a0};
        bus0.in_b     = {b1, b0};
        @(negedge tb_clk);
        while (!bus0.in_ready && n < 50) begin
            @(negedge tb_clk);
            n++;
        end
        if (n >= 50) check("send_timeout", 64'd0, 64'd1);
        @(posedge tb_clk);
        #1;
        bus0.in_valid = 1'b0;
    endtask

    task automatic send_rand();
        send(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!bus0.out_valid && n < 40) begin
            @(posedge tb_clk);
            #1;
            n++;
        end
        check(tag, 64'(bus0.out_valid), 64'd1);
    endtask

    task automatic drain(input string tag);
        bus0.out_ready = 1'b1;
        wait_valid(tag);
        @(posedge tb_clk);
        #1;
        check({tag, "_done"}, 64'(bus0.out_valid), 64'd0);
    endtask

    logic [31:0] held;

    initial begin
        rst_n          = 1'b0;
        enable         = 1'b1;
        clear          = 1'b0;
        bus0.in_valid  = 1'b0;
        bus0.in_a      = '0;
        bus0.in_b      = '0;
        bus0.out_ready = 1'b1;

        // Reset
        @(posedge tb_clk);
        @(posedge tb_clk);
        #1;
        check("rst_out_valid", 64'(bus0.out_valid), 64'd0);
        check("rst_out_data",  64'(bus0.out_data),  64'd0);
        check("rst_out_ovf",   64'(bus0.out_ovf),   64'd0);
        check("rst_busy",      64'(busy0),          64'd0);
        check("rst_in_ready",  64'(bus0.in_ready),  64'd0);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", 64'(bus0.in_ready), 64'd1);
        check("rel_busy",     64'(busy0),         64'd0);

        // Basic MAC with latency checks
        repeat (4) send(16'h0100, 16'h0200, 16'hFE80, 16'h0100);
        check("fin_out_valid", 64'(bus0.out_valid), 64'd0);
        check("fin_in_ready",  64'(bus0.in_ready),  64'd0);
        check("fin_busy",      64'(busy0),          64'd1);
        @(posedge tb_clk);
        #1;
        check("lat_out_valid", 64'(bus0.out_valid), 64'd1);
        check("basic_data",    64'(bus0.out_data),  64'h0000_0000_FA00_0800);
        check("basic_ovf",     64'(bus0.out_ovf),   64'd0);
        check("hold_in_ready", 64'(bus0.in_ready),  64'd0);
        @(posedge tb_clk);
        #1;
        check("xfer_out_valid", 64'(bus0.out_valid), 64'd0);
        check("xfer_in_ready",  64'(bus0.in_ready),  64'd1);
        check("xfer_keep_data", 64'(bus0.out_data),  64'h0000_0000_FA00_0800);

        // Saturation, both modes
        repeat (4) send(16'h7FFF, 16'h7FFF, 16'h8000, 16'h7FFF);
        wait_valid("sat_valid");
        check("sat_data",  64'(bus0.out_data), 64'h0000_0000_8000_7FFF);
        check("wrap_data", 64'(bus1.out_data), 64'h0000_0000_0200_FC00);
        check("sat_ovf",   64'(bus0.out_ovf),  64'd3);
        check("wrap_ovf",  64'(bus1.out_ovf),  64'd3);
        drain("sat_drain");

        // Backpressure
        bus0.out_ready = 1'b0;
        repeat (4) send_rand();
        wait_valid("bp_valid");
        held          = bus0.out_data;
        bus0.in_valid = 1'b1;
        bus0.in_a     = 32'($urandom);
        bus0.in_b     = 32'($urandom);
        for (int i = 0; i < 5; i++) begin
            @(posedge tb_clk);
            #1;
            check("bp_in_ready",  64'(bus0.in_ready),  64'd0);
            check("bp_out_valid", 64'(bus0.out_valid), 64'd1);
            check("bp_out_data",  64'(bus0.out_data),  64'(held));
        end
        bus0.out_ready = 1'b1;
        @(posedge tb_clk);
        #1;
        check("bp_xfer_in_ready", 64'(bus0.in_ready), 64'd1);
        @(posedge tb_clk);
        #1;
        bus0.in_valid = 1'b0;
        repeat (3) send_rand();
        drain("bp_drain");

        // Enable gap
        repeat (2) send_rand();
        enable        = 1'b0;
        bus0.in_valid = 1'b1;
        bus0.in_a     = 32'($urandom);
        bus0.in_b     = 32'($urandom);
        for (int i = 0; i < 3; i++) begin
            @(posedge tb_clk);
            #1;
            check("en_in_ready", 64'(bus0.in_ready), 64'd0);
            check("en_busy",     64'(busy0),         64'd1);
        end
        bus0.in_valid = 1'b0;
        enable        = 1'b1;
        repeat (2) send_rand();
        drain("en_drain");

        // Clear mid-accumulation
        repeat (3) send_rand();
        clear = 1'b1;
        #1;
        check("clr_in_ready", 64'(bus0.in_ready), 64'd0);
        @(posedge tb_clk);
        #1;
        clear = 1'b0;
        check("clr_busy", 64'(busy0), 64'd0);
        repeat (4) send(16'h0080, 16'h0300, 16'hFF00, 16'h0040);
        drain("clr_drain");

        // Asynchronous reset while holding a result
        bus0.out_ready = 1'b0;
        repeat (4) send_rand();
        wait_valid("ar_valid");
        @(posedge tb_clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("ar_out_valid", 64'(bus0.out_valid), 64'd0);
        check("ar_out_data",  64'(bus0.out_data),  64'd0);
        check("ar_busy",      64'(busy0),          64'd0);
        @(posedge tb_clk);
        #1;
        rst_n          = 1'b1;
        bus0.out_ready = 1'b1;
        repeat (4) send_rand();
        drain("post_rst_drain");

        repeat (3) @(posedge tb_clk);
        #1;
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
